// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external combinational ALU among NREQ requesters.
// One operation at a time: grant (IDLE), evaluate (EXEC), hold result until accepted (RESP).

package alu_arbiter_pkg;
    typedef logic [31:0] data_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_XOR} type_op;
endpackage

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DATA_W = $bits(data_t),
    parameter int ID_W   = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    input  type_op                 req_op [NREQ],
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output type_op                 alu_op,
    input  logic [DATA_W-1:0]      alu_r,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_r,
    output logic [ID_W-1:0]        rsp_id
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q,     state_d;
    logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [ID_W-1:0]   id_q,        id_d;
    logic [DATA_W-1:0] alu_a_q,     alu_a_d;
    logic [DATA_W-1:0] alu_b_q,     alu_b_d;
    type_op            alu_op_q,    alu_op_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_r_q,     rsp_r_d;
    logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;

    logic              grant_found;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   scan_idx;
    logic [DATA_W-1:0] win_a;
    logic [DATA_W-1:0] win_b;
    type_op            win_op;

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        winner      = '0;
        scan_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = ID_W'((int'(rr_ptr_q) + k) % NREQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                winner      = scan_idx;
            end
        end
    end

    assign win_a  = req_a[int'(winner)*DATA_W +: DATA_W];
    assign win_b  = req_b[int'(winner)*DATA_W +: DATA_W];
    assign win_op = req_op[winner];

    always_comb begin
        req_ready = '0;
        if (!rst && state_q == IDLE && grant_found) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_r_d     = rsp_r_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    alu_a_d  = win_a;
                    alu_b_d  = win_b;
                    alu_op_d = win_op;
                    id_d     = winner;
                    rr_ptr_d = (int'(winner) == NREQ - 1) ? '0 : winner + ID_W'(1);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_r_d     = alu_r;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= OP_ADD;
            rsp_valid_q <= 1'b0;
            rsp_r_q     <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_r_q     <= rsp_r_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: stimulus pushes expected responses into a queue,
// a negedge monitor pops and compares on every accepted response.

module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int NREQ   = 4;
    localparam int DATA_W = 32;
    localparam int ID_W   = 2;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*DATA_W-1:0] req_a;
    logic [NREQ*DATA_W-1:0] req_b;
    type_op                 req_op [NREQ];
    logic [DATA_W-1:0]      alu_a;
    logic [DATA_W-1:0]      alu_b;
    type_op                 alu_op;
    logic [DATA_W-1:0]      alu_r;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DATA_W-1:0]      rsp_r;
    logic [ID_W-1:0]        rsp_id;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] r;
    } exp_t;
    exp_t sb[$];

    alu_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_r     (alu_r),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_r     (rsp_r),
        .rsp_id    (rsp_id)
    );

    // Reference ALU sitting on the arbiter's ALU port group.
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_r = alu_a + alu_b;
            OP_SUB:  alu_r = alu_a - alu_b;
            OP_AND:  alu_r = alu_a & alu_b;
            OP_XOR:  alu_r = alu_a ^ alu_b;
            default: alu_r = '0;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input type_op op);
        req_a[i*DATA_W +: DATA_W] = a;
        req_b[i*DATA_W +: DATA_W] = b;
        req_op[i] = op;
    endtask

    task automatic expect_rsp(input int id, input logic [DATA_W-1:0] r);
        exp_t e;
        e.id = ID_W'(id);
        e.r  = r;
        sb.push_back(e);
    endtask

    // Waits for a grant, checks the one-hot pattern, returns just after the grant edge.
    task automatic wait_grant(input string name, input logic [NREQ-1:0] exp, output int gcyc);
        bit seen;
        seen = 1'b0;
        gcyc = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                seen = 1'b1;
                gcyc = cyc;
                check(name, 64'(req_ready), 64'(exp));
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: no grant within 20 cycles, required %b", name, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id=%0d r=%0h, required no response", rsp_id, rsp_r);
            end else begin
                e = sb.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(e.id));
                check("rsp_r", 64'(rsp_r), 64'(e.r));
            end
        end
    end

    initial begin : stimulus
        int g;
        int prev;
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NREQ; i++) req_op[i] = OP_ADD;

        // Reset state, with every requester asking while rst is high.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_r", 64'(rsp_r), 64'h0);
        check("rst_rsp_id", 64'(rsp_id), 64'h0);
        check("rst_alu_a", 64'(alu_a), 64'h0);
        check("rst_alu_b", 64'(alu_b), 64'h0);
        check("rst_alu_op", 64'(alu_op), 64'(OP_ADD));
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("idle_no_req", 64'(req_ready), 64'h0);
        @(posedge clk);
        #1;

        // Single request from requester 2: 5 + 3.
        set_req(2, 32'd5, 32'd3, OP_ADD);
        req_valid = 4'b0100;
        expect_rsp(2, 32'd8);
        wait_grant("single_grant", 4'b0100, g);
        req_valid = '0;
        @(negedge clk);
        check("single_exec_valid", 64'(rsp_valid), 64'h0);
        check("single_alu_a", 64'(alu_a), 64'd5);
        check("single_alu_b", 64'(alu_b), 64'd3);
        check("single_exec_ready", 64'(req_ready), 64'h0);
        @(negedge clk);
        check("single_latency", 64'(rsp_valid), 64'h1);
        @(posedge clk);
        #1;

        // Wrap-around: rr_ptr is 3 after the grant to 2.
        set_req(3, 32'd7, 32'd9, OP_ADD);
        req_valid = 4'b1000;
        expect_rsp(3, 32'd16);
        wait_grant("wrap_grant3", 4'b1000, g);
        set_req(0, 32'd20, 32'd6, OP_SUB);
        set_req(3, 32'd50, 32'd8, OP_XOR);
        req_valid = 4'b1001;
        expect_rsp(0, 32'd14);
        wait_grant("wrap_0_over_3", 4'b0001, g);
        set_req(1, 32'h0000_FF00, 32'h0000_0FF0, OP_AND);
        req_valid = 4'b1011;
        expect_rsp(1, 32'h0000_0F00);
        wait_grant("wrap_ptr_is_1", 4'b0010, g);
        req_valid = 4'b1001;
        expect_rsp(3, 32'd58);
        wait_grant("wrap_then_3", 4'b1000, g);
        req_valid = 4'b0001;
        expect_rsp(0, 32'd14);
        wait_grant("wrap_then_0", 4'b0001, g);
        req_valid = '0;
        drain();

        // Operand extremes: FFFFFFFF + 1 wraps to 0.
        set_req(1, 32'hFFFF_FFFF, 32'd1, OP_ADD);
        req_valid = 4'b0010;
        expect_rsp(1, 32'h0);
        wait_grant("extreme_grant", 4'b0010, g);
        req_valid = '0;
        drain();

        // Backpressure: hold rsp_ready low for 10 cycles with requester 2 pending.
        rsp_ready = 1'b0;
        set_req(0, 32'h1234_0000, 32'h0000_5678, OP_ADD);
        req_valid = 4'b0001;
        expect_rsp(0, 32'h1234_5678);
        wait_grant("bp_grant0", 4'b0001, g);
        set_req(2, 32'd9, 32'd4, OP_SUB);
        req_valid = 4'b0100;
        expect_rsp(2, 32'd5);
        @(negedge clk);
        check("bp_exec_valid", 64'(rsp_valid), 64'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 64'(rsp_valid), 64'h1);
            check("bp_rsp_r", 64'(rsp_r), 64'h1234_5678);
            check("bp_rsp_id", 64'(rsp_id), 64'h0);
            check("bp_req_ready", 64'(req_ready), 64'h0);
            check("bp_alu_a", 64'(alu_a), 64'h1234_0000);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_grant_after_hs", 64'(req_ready), 64'(4'b0100));
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();

        // Reset during EXEC discards the operation and clears rr_ptr.
        set_req(1, 32'd77, 32'd1, OP_ADD);
        req_valid = 4'b0010;
        wait_grant("rst_mid_grant", 4'b0010, g);
        req_valid = '0;
        rst       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_mid_alu_a", 64'(alu_a), 64'h0);
        check("rst_mid_alu_op", 64'(alu_op), 64'(OP_ADD));
        check("rst_mid_req_ready", 64'(req_ready), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All four requesting continuously: order 0,1,2,3,0 at one grant per 3 cycles.
        set_req(0, 32'd100, 32'd23, OP_ADD);
        set_req(1, 32'd100, 32'd23, OP_SUB);
        set_req(2, 32'hF0F0_1234, 32'h0FF0_FF00, OP_AND);
        set_req(3, 32'hAAAA_5555, 32'hFFFF_0000, OP_XOR);
        req_valid = 4'b1111;
        expect_rsp(0, 32'd123);
        expect_rsp(1, 32'd77);
        expect_rsp(2, 32'h00F0_1200);
        expect_rsp(3, 32'h5555_5555);
        expect_rsp(0, 32'd123);
        wait_grant("all_grant0", 4'b0001, prev);
        wait_grant("all_grant1", 4'b0010, g);
        check("all_gap1", 64'(g - prev), 64'd3);
        prev = g;
        wait_grant("all_grant2", 4'b0100, g);
        check("all_gap2", 64'(g - prev), 64'd3);
        prev = g;
        wait_grant("all_grant3", 4'b1000, g);
        check("all_gap3", 64'(g - prev), 64'd3);
        prev = g;
        wait_grant("all_grant0_again", 4'b0001, g);
        check("all_gap4", 64'(g - prev), 64'd3);
        req_valid = '0;
        drain();

        repeat (3) begin
            @(negedge clk);
            check("final_idle_valid", 64'(rsp_valid), 64'h0);
        end
        check("sb_drained", 64'(sb.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
